// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transaction arbiter: FSM states,
// field widths and the {rd_wr, addr} header byte the master shifts out first.
package spi_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned HDR_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    StIdle,
    StFrame,
    StCapture,
    StGap
  } arb_state_e;

  function automatic logic [HDR_W-1:0] pack_hdr(input logic              rd_wr,
                                                input logic [ADDR_W-1:0] addr);
    return {rd_wr, addr};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request at or above ptr_i,
// wrapping around to bit 0. Produces a one-hot grant and its binary index.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] req_hi;
  logic [NUM_REQ-1:0] sel;

  always_comb begin
    mask   = '1 << ptr_i;
    req_hi = req_i & mask;
    // Nothing at or above the pointer: wrap and take the lowest request overall.
    sel    = (|req_hi) ? req_hi : req_i;
    gnt_o  = '0;
    idx_o  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (sel[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one spi_master between NUM_REQ requesters: round-robin grant, one
// frame per request, cs sanity check, then a one-hot completion with read data.
module spi_txn_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned FRAME_LEN = 19,
  parameter int unsigned GAP_LEN   = 2
) (
  input  logic                      mclk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_rd_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      m_start,
  output logic                      m_rd_wr,
  output logic [ADDR_W-1:0]         m_address,
  output logic [DATA_W-1:0]         m_out_data,
  input  logic [DATA_W-1:0]         m_in_data,
  input  logic                      m_cs
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(FRAME_LEN + GAP_LEN + 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CS_CHK     = CNT_W'(FRAME_LEN / 2);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LEN - 1);

  arb_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [HDR_W-1:0]    hdr_q, hdr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;
  logic                m_start_q, m_start_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]    arb_idx;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req_i(req_valid),
    .ptr_i(ptr_q),
    .gnt_o(arb_gnt),
    .idx_o(arb_idx)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    hdr_d       = hdr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    m_start_d   = m_start_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          req_ready_d = arb_gnt;
          gnt_d       = arb_gnt;
          hdr_d       = pack_hdr(req_rd_wr[arb_idx], req_addr[arb_idx*ADDR_W +: ADDR_W]);
          wdata_d     = req_wdata[arb_idx*DATA_W +: DATA_W];
          m_start_d   = 1'b1;
          cnt_d       = '0;
          ptr_d       = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          state_d     = StFrame;
        end
      end
      StFrame: begin
        cnt_d = cnt_q + 1'b1;
        // cs must be asserted (low) mid-frame.
        if (cnt_q == CS_CHK && m_cs) begin
          err_d = 1'b1;
        end
        if (cnt_q == FRAME_LAST) begin
          m_start_d = 1'b0;
          state_d   = StCapture;
        end
      end
      StCapture: begin
        rsp_valid_d = gnt_q;
        rsp_rdata_d = hdr_q[HDR_W-1] ? m_in_data : '0;
        // cs must be released by the time the frame is over.
        rsp_err_d   = err_q | ~m_cs;
        err_d       = 1'b0;
        cnt_d       = '0;
        state_d     = StGap;
      end
      StGap: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == GAP_LAST) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ptr_q       <= '0;
      gnt_q       <= '0;
      hdr_q       <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      m_start_q   <= 1'b0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      hdr_q       <= hdr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      m_start_q   <= m_start_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != StIdle);
  assign m_start    = m_start_q;
  assign m_rd_wr    = hdr_q[HDR_W-1];
  assign m_address  = hdr_q[ADDR_W-1:0];
  assign m_out_data = wdata_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: a transaction-timeline model checked every cycle,
// a simple master/slave stand-in, and directed scenarios with literal expectations.
module tb_spi_txn_arbiter;

  localparam int N       = 4;
  localparam int FL      = 19;
  localparam int GL      = 2;
  localparam int SPACING = 1 + FL + 1 + GL;

  logic           mclk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_rd_wr = '0;
  logic [N*7-1:0] req_addr = '0;
  logic [N*8-1:0] req_wdata = '0;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [7:0]     rsp_rdata;
  logic           rsp_err, busy, m_start, m_rd_wr;
  logic [6:0]     m_address;
  logic [7:0]     m_out_data, m_in_data;
  logic           m_cs;

  spi_txn_arbiter #(
    .NUM_REQ(N),
    .FRAME_LEN(FL),
    .GAP_LEN(GL)
  ) dut (
    .mclk(mclk),
    .reset(reset),
    .req_valid(req_valid),
    .req_rd_wr(req_rd_wr),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .busy(busy),
    .m_start(m_start),
    .m_rd_wr(m_rd_wr),
    .m_address(m_address),
    .m_out_data(m_out_data),
    .m_in_data(m_in_data),
    .m_cs(m_cs)
  );

  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  // Master/slave stand-in: cs low while start is high, slave latches the frame payload.
  logic       force_cs = 1'b0;
  logic [7:0] slave_out_data = '0;
  logic       slave_rd_wr = 1'b0;
  logic [6:0] slave_address = '0;
  logic [7:0] slave_in_data = '0;
  int         run_len = 0;
  int         last_len = 0;

  assign m_cs      = force_cs | ~m_start;
  assign m_in_data = slave_rd_wr ? slave_out_data : 8'hFF;

  always @(posedge mclk) begin
    if (m_start) begin
      slave_rd_wr   <= m_rd_wr;
      slave_address <= m_address;
      slave_in_data <= m_out_data;
      run_len       <= run_len + 1;
    end else begin
      if (run_len != 0) last_len <= run_len;
      run_len <= 0;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Timeline model: k = cycles since the grant edge (-1 when idle).
  // k 0..FL-1 frame, FL capture, FL+1..FL+GL gap, then idle again.
  int           k = -1;
  int           ptr = 0;
  int           mg = 0;
  logic         mrd = 1'b0;
  logic         merr = 1'b0;
  logic         model_live = 1'b0;
  logic [N-1:0] exp_req_ready = '0;
  logic [N-1:0] exp_rsp_valid = '0;
  logic [7:0]   exp_rdata = '0;
  logic         exp_err = 1'b0;
  logic         exp_m_start = 1'b0;
  logic         exp_busy = 1'b0;
  logic         exp_rd_wr = 1'b0;
  logic [6:0]   exp_addr = '0;
  logic [7:0]   exp_wdata = '0;

  always @(posedge mclk) begin
    logic cs_now;
    bit   found;
    int   c;
    cs_now        = force_cs | !(k >= 0 && k < FL);
    exp_req_ready = '0;
    exp_rsp_valid = '0;
    if (!reset) begin
      k = -1; ptr = 0; merr = 1'b0;
      exp_rdata = '0; exp_err = 1'b0;
      exp_rd_wr = 1'b0; exp_addr = '0; exp_wdata = '0;
    end else begin
      if (k == FL / 2 && cs_now) merr = 1'b1;
      if (k == FL && !cs_now) merr = 1'b1;
      if (k == FL) begin
        exp_rsp_valid[mg] = 1'b1;
        exp_rdata = mrd ? slave_out_data : 8'h00;
        exp_err   = merr;
        merr      = 1'b0;
      end
      if (k < 0) begin
        found = 0;
        for (int j = 0; j < N; j++) begin
          c = (ptr + j) % N;
          if (!found && req_valid[c]) begin
            found = 1;
            mg    = c;
          end
        end
        if (found) begin
          k = 0;
          exp_req_ready[mg] = 1'b1;
          mrd       = req_rd_wr[mg];
          exp_rd_wr = req_rd_wr[mg];
          exp_addr  = req_addr[mg*7 +: 7];
          exp_wdata = req_wdata[mg*8 +: 8];
          ptr       = (mg + 1) % N;
        end
      end else if (k == FL + GL) begin
        k = -1;
      end else begin
        k++;
      end
    end
    exp_m_start = (k >= 0 && k < FL);
    exp_busy    = (k >= 0);
    model_live  = 1'b1;
  end

  always @(negedge mclk) begin
    if (model_live) begin
      chk("req_ready", req_ready, exp_req_ready);
      chk("rsp_valid", rsp_valid, exp_rsp_valid);
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("rsp_err", rsp_err, exp_err);
      chk("m_start", m_start, exp_m_start);
      chk("busy", busy, exp_busy);
      chk("m_rd_wr", m_rd_wr, exp_rd_wr);
      chk("m_address", m_address, exp_addr);
      chk("m_out_data", m_out_data, exp_wdata);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic set_req(input int i, input logic rd, input logic [6:0] a, input logic [7:0] d);
    req_rd_wr[i]       = rd;
    req_addr[i*7 +: 7] = a;
    req_wdata[i*8 +: 8] = d;
    req_valid[i]       = 1'b1;
  endtask

  task automatic wait_ready(input int maxc, output logic [N-1:0] oh, output int at);
    bit done;
    done = 0; oh = '0; at = -1;
    for (int c = 0; c < maxc && !done; c++) begin
      @(negedge mclk);
      if (req_ready != '0) begin
        oh = req_ready; at = cyc; done = 1;
      end
    end
    chk("ready_seen", done, 1);
  endtask

  task automatic wait_rsp(input int maxc, output logic [N-1:0] oh, output logic [7:0] rd,
                          output logic er);
    bit done;
    done = 0; oh = '0; rd = '0; er = 1'b0;
    for (int c = 0; c < maxc && !done; c++) begin
      @(negedge mclk);
      if (rsp_valid != '0) begin
        oh = rsp_valid; rd = rsp_rdata; er = rsp_err; done = 1;
      end
    end
    chk("rsp_seen", done, 1);
  endtask

  logic [N-1:0] oh, roh, exp_oh;
  logic [7:0]   rd;
  logic         er;
  int           at, at1, prev_at, nrsp;
  int           order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int           got[N];

  initial begin
    tick(3);
    reset = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_m_start", m_start, 0);
    chk("rst_req_ready", req_ready, 0);

    // Single write from requester 0.
    set_req(0, 1'b0, 7'h15, 8'hA5);
    wait_ready(10, oh, at);
    chk("t1_ready", oh, 4'b0001);
    req_valid[0] = 1'b0;
    tick(1);
    chk("t1_ready_pulse", req_ready, 0);
    wait_rsp(40, roh, rd, er);
    chk("t1_rsp_who", roh, 4'b0001);
    chk("t1_rdata", rd, 8'h00);
    chk("t1_err", er, 0);
    chk("t1_start_len", last_len, 19);
    chk("t1_slave_addr", slave_address, 7'h15);
    chk("t1_slave_data", slave_in_data, 8'hA5);

    // Single read from requester 2.
    slave_out_data = 8'h5E;
    set_req(2, 1'b1, 7'h3C, 8'h00);
    wait_ready(40, oh, at);
    chk("t2_ready", oh, 4'b0100);
    req_valid[2] = 1'b0;
    wait_rsp(40, roh, rd, er);
    chk("t2_rsp_who", roh, 4'b0100);
    chk("t2_rdata", rd, 8'h5E);
    chk("t2_err", er, 0);
    chk("t2_slave_rd_wr", slave_rd_wr, 1);
    chk("t2_slave_addr", slave_address, 7'h3C);

    // Contention from a fresh pointer; each requester stays valid for two services.
    tick(2);
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      set_req(i, 1'b0, 7'(8'h10 + i), 8'(8'hC0 + i));
      got[i] = 0;
    end
    prev_at = 0;
    for (int n = 0; n < 8; n++) begin
      wait_ready(40, oh, at);
      exp_oh = '0;
      exp_oh[order[n]] = 1'b1;
      chk($sformatf("t3_grant%0d", n), oh, exp_oh);
      if (n > 0) chk("t3_spacing", at - prev_at, SPACING);
      prev_at = at;
      for (int i = 0; i < N; i++) begin
        if (oh[i]) begin
          got[i]++;
          if (got[i] == 2) req_valid[i] = 1'b0;
        end
      end
    end
    wait_rsp(40, roh, rd, er);
    chk("t3_last_rsp", roh, 4'b1000);

    // Late arrival: requester 3 shows up during requester 1's frame.
    set_req(1, 1'b0, 7'h31, 8'h11);
    wait_ready(40, oh, at1);
    chk("t4_ready1", oh, 4'b0010);
    req_valid[1] = 1'b0;
    tick(5);
    set_req(3, 1'b0, 7'h33, 8'h33);
    wait_ready(40, oh, at);
    chk("t4_ready3", oh, 4'b1000);
    chk("t4_delay", at - at1, SPACING);
    req_valid[3] = 1'b0;
    wait_rsp(40, roh, rd, er);
    chk("t4_rsp_who", roh, 4'b1000);

    // Protocol error: cs stuck high for a whole frame, then a clean read.
    force_cs = 1'b1;
    set_req(0, 1'b0, 7'h22, 8'h5A);
    wait_ready(40, oh, at);
    req_valid[0] = 1'b0;
    wait_rsp(40, roh, rd, er);
    chk("t5_err_who", roh, 4'b0001);
    chk("t5_err", er, 1);
    force_cs = 1'b0;
    slave_out_data = 8'h81;
    set_req(0, 1'b1, 7'h23, 8'h00);
    wait_ready(40, oh, at);
    req_valid[0] = 1'b0;
    wait_rsp(40, roh, rd, er);
    chk("t5_clean_err", er, 0);
    chk("t5_clean_rdata", rd, 8'h81);

    // Reset in the middle of requester 1's frame.
    set_req(1, 1'b0, 7'h44, 8'h99);
    wait_ready(40, oh, at);
    chk("t6_ready1", oh, 4'b0010);
    req_valid[1] = 1'b0;
    tick(9);
    reset = 1'b0;
    tick(1);
    chk("t6_rst_m_start", m_start, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_addr", m_address, 0);
    chk("t6_rst_rdata", rsp_rdata, 0);
    reset = 1'b1;
    nrsp = 0;
    for (int c = 0; c < 30; c++) begin
      tick(1);
      if (rsp_valid != '0) nrsp++;
    end
    chk("t6_no_rsp", nrsp, 0);
    set_req(0, 1'b0, 7'h50, 8'h01);
    set_req(1, 1'b0, 7'h51, 8'h02);
    wait_ready(40, oh, at);
    chk("t6_first", oh, 4'b0001);
    req_valid[0] = 1'b0;
    wait_ready(40, oh, at);
    chk("t6_second", oh, 4'b0010);
    req_valid[1] = 1'b0;
    wait_rsp(40, roh, rd, er);
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
